// File: rtl/tiny_fpga_cfg_ctrl.sv
// tiny_fpga_cfg_ctrl
// Configuration/run sequencer for the 2x2 tiny FPGA fabric. It takes a 1-bit
// AXI-stream bitstream and shifts it into the fabric configuration chain, one
// bit per cycle. It checks that the stream length matches CFG_BITS exactly.
// The fabric may only run on a complete, error-free configuration.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg               level request to load a new configuration
//   run               level request to run the configured fabric
//   s_tvalid/s_tready/s_tdata/s_tlast   1-bit bitstream input
//   chain_clear       one-cycle pulse clearing the configuration chain
//   chain_shift_en    shift chain_shift_data into the chain this cycle
//   chain_shift_data  bit to shift
//   cfg_ready         fabric holds a complete valid configuration
//   cfg_error         last load failed the length check (sticky until CLEAR)
//   run_en            fabric run enable
//   bit_count         bits accepted in the current or last load (saturating)
//
// Handshake: a bit is transferred on any rising edge where s_tvalid and
// s_tready are both high. s_tready depends on state only, never on s_tvalid,
// and the bit appears on chain_shift_* exactly one cycle later.

module tiny_fpga_cfg_ctrl #(
  parameter int CFG_BITS = 96,
  parameter int CNT_W    = $clog2(CFG_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg,
  input  logic             run,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tdata,
  input  logic             s_tlast,
  output logic             chain_clear,
  output logic             chain_shift_en,
  output logic             chain_shift_data,
  output logic             cfg_ready,
  output logic             cfg_error,
  output logic             run_en,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_DONE  = 3'd3,
    S_READY = 3'd4,
    S_RUN   = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CFG_BITS);

  state_t state;
  state_t state_nxt;
  logic   loaded;
  logic   hs;
  logic   at_last;
  logic   len_bad;

  assign hs      = s_tvalid & s_tready;
  assign at_last = (bit_count == LAST_IDX);
  // tlast before the final index is a short stream; a missing tlast on the
  // final index is a long stream. Either way the lengths disagree.
  assign len_bad = hs & (s_tlast ^ at_last);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cfg) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        state_nxt = cfg ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        // Abort wins over any length verdict reached in the same cycle.
        if (!cfg) begin
          state_nxt = S_IDLE;
        end else if (hs && s_tlast && at_last) begin
          state_nxt = S_DONE;
        end else if (len_bad) begin
          state_nxt = S_ERROR;
        end
      end
      S_DONE: begin
        state_nxt = S_READY;
      end
      S_READY: begin
        if (cfg) begin
          state_nxt = S_CLEAR;
        end else if (run) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // cfg is deliberately ignored: reconfiguration needs run to drop first.
        if (!run) state_nxt = S_READY;
      end
      S_ERROR: begin
        if (!cfg) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode (state only)
  always_comb begin
    s_tready    = (state == S_LOAD);
    chain_clear = (state == S_CLEAR);
    cfg_ready   = ((state == S_READY) || (state == S_RUN)) && loaded;
    run_en      = (state == S_RUN);
  end

  // Datapath registers: counter, flags and the one-cycle shift stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_count        <= '0;
      loaded           <= 1'b0;
      cfg_error        <= 1'b0;
      chain_shift_en   <= 1'b0;
      chain_shift_data <= 1'b0;
    end else begin
      chain_shift_en   <= hs;
      chain_shift_data <= hs ? s_tdata : 1'b0;

      if (state == S_CLEAR) begin
        bit_count <= '0;
      end else if (hs && (bit_count != FULL_CNT)) begin
        bit_count <= bit_count + CNT_W'(1);
      end

      if (state == S_CLEAR) begin
        loaded <= 1'b0;
      end else if (state == S_DONE) begin
        loaded <= 1'b1;
      end

      if (state == S_CLEAR) begin
        cfg_error <= 1'b0;
      end else if ((state == S_LOAD) && cfg && len_bad) begin
        cfg_error <= 1'b1;
      end
    end
  end

endmodule
